// File: rtl/peripheral_msi_arbiter_ahb4.sv
// AHB4-Lite bus arbiter for the MSI interconnect. It selects one requester per address phase
// and publishes a registered one-hot grant together with the address-phase and data-phase owner indices.
module peripheral_msi_arbiter_ahb4 #(
  parameter int MASTERS        = 3,
  parameter int PRIO_BITS      = 3,
  parameter int MODE           = 1,
  parameter int MAX_HOLD       = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [MASTERS*PRIO_BITS-1:0]   mst_priority,
  input  logic [MASTERS-1:0]             mst_HSEL,
  input  logic [MASTERS*2-1:0]           mst_HTRANS,
  input  logic [MASTERS-1:0]             mst_HMASTLOCK,
  input  logic                           HREADY,
  output logic [MASTERS-1:0]             grant,
  output logic [$clog2(MASTERS)-1:0]     grant_idx,
  output logic [$clog2(MASTERS)-1:0]     data_idx,
  output logic                           locked
);

  localparam int IW = $clog2(MASTERS);
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam bit HOLD_EN = (MAX_HOLD != 0);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [IW-1:0] DEF_IDX = IW'(DEFAULT_MASTER);
  localparam logic [IW-1:0] RR_INIT = IW'(MASTERS - 1);
  localparam logic [MASTERS-1:0] ONE_OH = {{(MASTERS-1){1'b0}}, 1'b1};
  localparam logic [MASTERS-1:0] DEF_OH = ONE_OH << DEFAULT_MASTER;

  typedef enum logic [0:0] {ST_PARK = 1'b0, ST_OWN = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [MASTERS-1:0]    r_grant;
  logic [IW-1:0]         r_grant_idx;
  logic [IW-1:0]         r_data_idx;
  logic                  r_locked;
  logic [IW-1:0]         r_rr;
  logic [HW-1:0]         r_hold;
  logic [HW-1:0]         w_hold_nxt;

  logic [PRIO_BITS-1:0]  w_pri [MASTERS];
  logic [MASTERS-1:0]    w_req;
  logic [MASTERS-1:0]    w_cand;
  logic [MASTERS-1:0]    w_top;
  logic [1:0]            w_own_trans;
  logic                  w_own_lock;
  logic                  w_cont;
  logic                  w_others;
  logic                  w_expiry;
  logic                  w_arb;
  logic                  w_any;
  logic                  w_change;
  logic [PRIO_BITS-1:0]  w_max;
  logic [IW-1:0]         w_win_fix;
  logic [IW-1:0]         w_win_rr;
  logic [IW-1:0]         w_win;
  logic [IW-1:0]         w_next_idx;
  logic [MASTERS-1:0]    w_next_oh;

  for (genvar g = 0; g < MASTERS; g++) begin : g_pri
    assign w_pri[g] = mst_priority[g*PRIO_BITS +: PRIO_BITS];
  end

  // Request decode and the current owner's transfer/lock view
  always_comb begin
    w_req       = '0;
    w_own_trans = 2'b00;
    w_own_lock  = 1'b0;
    for (int i = 0; i < MASTERS; i++) begin
      w_req[i]    = mst_HSEL[i] & (mst_HTRANS[2*i +: 2] == 2'b10);
      w_own_trans = w_own_trans | ({2{r_grant[i]}} & mst_HTRANS[2*i +: 2]);
      w_own_lock  = w_own_lock | (r_grant[i] & mst_HMASTLOCK[i]);
    end
  end

  // SEQ and BUSY both have bit 0 set: the owner is inside a burst and must not be pre-empted
  assign w_cont   = w_own_trans[0];
  assign w_others = |(w_req & ~r_grant);
  assign w_expiry = HOLD_EN && (r_hold == HOLD_MAX);
  assign w_arb    = HREADY & ~w_cont & ~w_own_lock;
  assign w_cand   = w_expiry ? (w_req & ~r_grant) : w_req;
  assign w_any    = |w_cand;

  // Winner selection: highest priority, then fixed or round-robin tie-break
  always_comb begin
    int idx;
    idx       = 0;
    w_max     = '0;
    w_top     = '0;
    w_win_fix = '0;
    w_win_rr  = '0;
    for (int i = 0; i < MASTERS; i++) begin
      w_max = (w_cand[i] && (w_pri[i] > w_max)) ? w_pri[i] : w_max;
    end
    for (int i = 0; i < MASTERS; i++) begin
      w_top[i] = w_cand[i] && (w_pri[i] == w_max);
    end
    for (int i = MASTERS - 1; i >= 0; i--) begin
      w_win_fix = w_top[i] ? IW'(i) : w_win_fix;
    end
    // Scan farthest-first so the nearest candidate after the pointer is written last
    for (int k = MASTERS; k >= 1; k--) begin
      idx = (int'(r_rr) + k) % MASTERS;
      for (int i = 0; i < MASTERS; i++) begin
        w_win_rr = (w_top[i] && (i == idx)) ? IW'(i) : w_win_rr;
      end
    end
  end

  assign w_win      = (MODE == 1) ? w_win_rr : w_win_fix;
  assign w_next_idx = w_any ? w_win : DEF_IDX;
  assign w_next_oh  = ONE_OH << w_next_idx;
  assign w_change   = w_arb && (w_next_idx != r_grant_idx);

  // Hold counter: counts owner beats while someone else is waiting
  always_comb begin
    w_hold_nxt = r_hold;
    if (!HREADY) begin
      w_hold_nxt = r_hold;
    end else if (w_change || !w_others) begin
      w_hold_nxt = '0;
    end else if (w_own_trans[1] && (r_hold != HOLD_MAX)) begin
      w_hold_nxt = r_hold + HW'(1);
    end else begin
      w_hold_nxt = r_hold;
    end
  end

  // Next state: an arbitration point decides PARK/OWN, a retained bus stays OWN
  always_comb begin
    w_state_nxt = r_state;
    if (w_arb) begin
      w_state_nxt = w_any ? ST_OWN : ST_PARK;
    end else if (HREADY) begin
      w_state_nxt = ST_OWN;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Registered grant, owner indices, lock flag, RR pointer and hold counter
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= ST_PARK;
      r_grant     <= DEF_OH;
      r_grant_idx <= DEF_IDX;
      r_data_idx  <= DEF_IDX;
      r_locked    <= 1'b0;
      r_rr        <= RR_INIT;
      r_hold      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      if (HREADY) begin
        r_data_idx <= r_grant_idx;
        r_locked   <= w_own_lock;
        if (w_arb) begin
          r_grant     <= w_next_oh;
          r_grant_idx <= w_next_idx;
          if ((MODE == 1) && w_any) begin
            r_rr <= w_win;
          end
        end
      end
    end
  end

  assign grant     = r_grant;
  assign grant_idx = r_grant_idx;
  assign data_idx  = r_data_idx;
  assign locked    = r_locked;

endmodule
